// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit saturating counters: registered lookup for the fetch PC
// and a two-stage (read, then write) training pipeline fed by EX branch resolutions.
module branch_predict_unit #(
  parameter int unsigned INDEX_W  = 6,
  parameter int unsigned TAG_W    = 10,
  parameter logic [1:0]  CNT_INIT = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        query_ce,
  input  logic [31:0] query_pc,
  output logic [32:0] pta,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic        hit_o
);

  localparam int unsigned ENTRIES = 1 << INDEX_W;
  localparam int unsigned IDX_LSB = 2;
  localparam int unsigned IDX_MSB = INDEX_W + 1;
  localparam int unsigned TAG_LSB = INDEX_W + 2;
  localparam int unsigned TAG_MSB = INDEX_W + TAG_W + 1;

  logic [ENTRIES-1:0] valid_mem;
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [31:0]        tgt_mem [ENTRIES];
  logic [1:0]         cnt_mem [ENTRIES];

  logic               p_valid;
  logic [INDEX_W-1:0] p_idx;
  logic [TAG_W-1:0]   p_tag;
  logic               p_taken;
  logic [31:0]        p_target;
  logic               p_hit;
  logic [1:0]         p_cnt;

  logic               wr_en;
  logic [31:0]        wr_target;
  logic [1:0]         wr_cnt;

  logic [INDEX_W-1:0] q_idx;
  logic [TAG_W-1:0]   q_tag_in;
  logic               q_fwd;
  logic               q_hit;
  logic [31:0]        q_target;
  logic [1:0]         q_cnt;

  logic [INDEX_W-1:0] u_idx;
  logic [TAG_W-1:0]   u_tag_in;
  logic               u_fwd;
  logic               u_hit;
  logic [1:0]         u_cnt;

  logic               unused_bits;

  assign unused_bits = ^{stall[5:1], query_pc[31:TAG_MSB+1], query_pc[1:0],
                         upd_pc[31:TAG_MSB+1], upd_pc[1:0]};

  assign q_idx    = query_pc[IDX_MSB:IDX_LSB];
  assign q_tag_in = query_pc[TAG_MSB:TAG_LSB];
  assign u_idx    = upd_pc[IDX_MSB:IDX_LSB];
  assign u_tag_in = upd_pc[TAG_MSB:TAG_LSB];

  // U2 write data: counter step on a hit, allocation on a taken miss
  always_comb begin
    wr_en     = 1'b0;
    wr_target = p_target;
    wr_cnt    = CNT_INIT;
    if (p_valid) begin
      if (p_hit) begin
        wr_en = 1'b1;
        if (p_taken) begin
          wr_cnt = (p_cnt == 2'b11) ? 2'b11 : p_cnt + 2'b01;
        end else begin
          wr_cnt    = (p_cnt == 2'b00) ? 2'b00 : p_cnt - 2'b01;
          wr_target = tgt_mem[p_idx];
        end
      end else if (p_taken) begin
        wr_en = 1'b1;
      end
    end
  end

  // Fetch read port, forwarding the entry being written this cycle
  always_comb begin
    q_fwd    = wr_en && (p_idx == q_idx);
    q_target = q_fwd ? wr_target : tgt_mem[q_idx];
    q_cnt    = q_fwd ? wr_cnt : cnt_mem[q_idx];
    q_hit    = query_ce && (q_fwd ? (p_tag == q_tag_in)
                                  : (valid_mem[q_idx] && (tag_mem[q_idx] == q_tag_in)));
  end

  // U1 read port, same forwarding so back-to-back updates chain correctly
  always_comb begin
    u_fwd = wr_en && (p_idx == u_idx);
    u_cnt = u_fwd ? wr_cnt : cnt_mem[u_idx];
    u_hit = u_fwd ? (p_tag == u_tag_in)
                  : (valid_mem[u_idx] && (tag_mem[u_idx] == u_tag_in));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_mem <= '0;
      p_valid   <= 1'b0;
      p_idx     <= '0;
      p_tag     <= '0;
      p_taken   <= 1'b0;
      p_target  <= 32'h0;
      p_hit     <= 1'b0;
      p_cnt     <= 2'b00;
      pta       <= 33'h0;
      hit_o     <= 1'b0;
    end else begin
      if (wr_en) begin
        valid_mem[p_idx] <= 1'b1;
      end
      p_valid  <= upd_valid;
      p_idx    <= u_idx;
      p_tag    <= u_tag_in;
      p_taken  <= upd_taken;
      p_target <= upd_target;
      p_hit    <= u_hit;
      p_cnt    <= u_cnt;
      if (flush) begin
        pta   <= 33'h0;
        hit_o <= 1'b0;
      end else if (!stall[0]) begin
        pta   <= {q_hit && q_cnt[1], q_hit ? q_target : 32'h0};
        hit_o <= q_hit;
      end
    end
  end

  // Entry payload is meaningful only once its valid bit is set, so it carries no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[p_idx] <= p_tag;
      tgt_mem[p_idx] <= wr_target;
      cnt_mem[p_idx] <= wr_cnt;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: hand-computed predictions after training,
// counter saturation, aliasing, stall/flush, write-cycle forwarding and reset.
module tb_branch_predict_unit;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        query_ce;
  logic [31:0] query_pc;
  logic [32:0] pta;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        hit_o;

  int vec_cnt;
  int err_cnt;

  branch_predict_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .query_ce   (query_ce),
    .query_pc   (query_pc),
    .pta        (pta),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .hit_o      (hit_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one update for a single cycle (U1 capture at this edge)
  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = taken;
    upd_target = tgt;
    tick();
    upd_valid  = 1'b0;
  endtask

  task automatic query(input logic [31:0] pc);
    query_pc = pc;
    query_ce = 1'b1;
    tick();
    query_ce = 1'b0;
  endtask

  localparam logic [31:0] PC_A  = 32'h8000_1000;  // idx 0, tag 0x010
  localparam logic [31:0] PC_AL = 32'h8001_1000;  // idx 0, tag 0x110
  localparam logic [31:0] PC_B  = 32'h8000_4010;  // idx 4
  localparam logic [31:0] PC_C  = 32'h8000_6000;
  localparam logic [31:0] T_A   = 32'h8000_2000;

  initial begin
    vec_cnt    = 0;
    err_cnt    = 0;
    rst        = 1'b0;
    stall      = 6'h0;
    flush      = 1'b0;
    query_ce   = 1'b0;
    query_pc   = 32'h0;
    upd_valid  = 1'b0;
    upd_pc     = 32'h0;
    upd_taken  = 1'b0;
    upd_target = 32'h0;
    tick();
    tick();
    chk("reset_pta", pta, 33'h0);
    chk("reset_hit", {32'h0, hit_o}, 33'h0);
    rst = 1'b1;

    for (int i = 0; i < 3; i++) begin
      query(32'hBFC0_0000);
      chk("cold_pta", pta, 33'h0);
      chk("cold_hit", {32'h0, hit_o}, 33'h0);
    end

    // allocate: cnt 2, predicted taken
    upd(PC_A, 1'b1, T_A);
    tick();
    query(PC_A);
    chk("alloc_pta", pta, {1'b1, T_A});
    chk("alloc_hit", {32'h0, hit_o}, 33'h1);

    // three not-taken back to back: 2->1->0->0
    upd(PC_A, 1'b0, 32'h0);
    upd(PC_A, 1'b0, 32'h0);
    upd(PC_A, 1'b0, 32'h0);
    tick();
    query(PC_A);
    chk("floor_pta", pta, {1'b0, T_A});
    chk("floor_hit", {32'h0, hit_o}, 33'h1);

    upd(PC_A, 1'b1, T_A);
    tick();
    query(PC_A);
    chk("cnt1_pta", pta, {1'b0, T_A});

    // three taken back to back: 1->2->3->3
    upd(PC_A, 1'b1, T_A);
    upd(PC_A, 1'b1, T_A);
    upd(PC_A, 1'b1, T_A);
    tick();
    query(PC_A);
    chk("ceil_pta", pta, {1'b1, T_A});
    upd(PC_A, 1'b0, 32'h0);
    tick();
    query(PC_A);
    chk("cnt3to2_pta", pta, {1'b1, T_A});
    upd(PC_A, 1'b0, 32'h0);
    tick();
    query(PC_A);
    chk("cnt2to1_pta", pta, {1'b0, T_A});
    upd(PC_A, 1'b1, T_A);
    tick();
    query(PC_A);
    chk("cnt1to2_pta", pta, {1'b1, T_A});

    // stall holds the result, flush clears it even while stalled
    stall    = 6'h01;
    query_pc = 32'hBFC0_0000;
    query_ce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_pta", pta, {1'b1, T_A});
      chk("stall_hit", {32'h0, hit_o}, 33'h1);
    end
    flush = 1'b1;
    tick();
    chk("flush_pta", pta, 33'h0);
    chk("flush_hit", {32'h0, hit_o}, 33'h0);
    flush    = 1'b0;
    stall    = 6'h0;
    query_ce = 1'b0;

    // aliasing: same idx, different tag evicts PC_A
    upd(PC_AL, 1'b1, 32'h8000_3000);
    tick();
    query(PC_A);
    chk("alias_old_pta", pta, 33'h0);
    chk("alias_old_hit", {32'h0, hit_o}, 33'h0);
    query(PC_AL);
    chk("alias_new_pta", pta, {1'b1, 32'h8000_3000});

    // lookup in the U2 write cycle sees the entry being written
    upd(PC_B, 1'b1, 32'h8000_5550);
    query(PC_B);
    chk("fwd_alloc_pta", pta, {1'b1, 32'h8000_5550});
    chk("fwd_alloc_hit", {32'h0, hit_o}, 33'h1);
    upd(PC_B, 1'b0, 32'h0);
    query(PC_B);
    chk("fwd_dec_pta", pta, {1'b0, 32'h8000_5550});

    query_pc = PC_B;
    query_ce = 1'b0;
    tick();
    chk("ce_off_pta", pta, 33'h0);
    chk("ce_off_hit", {32'h0, hit_o}, 33'h0);

    // reset with an update in flight: table and pending update are lost
    upd(PC_C, 1'b1, 32'h8000_7000);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    query(PC_B);
    chk("post_rst_b", pta, 33'h0);
    query(PC_AL);
    chk("post_rst_al", pta, 33'h0);
    query(PC_C);
    chk("post_rst_c", pta, 33'h0);
    chk("post_rst_hit", {32'h0, hit_o}, 33'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Produces the `pta` prediction word, `{direction, target}`, for the instruction at the fetch PC. The next-PC/issue logic consumes it alongside the instruction pair.
- Trains on branch resolutions reported by EX (taken flag, actual target, branch PC).
- Direct-mapped BTB; each entry has a tag, a target and a 2-bit saturating counter.
- Lookup is registered, so `pta` aligns with the instruction returned by the icache one cycle after the PC is presented.

Parameters:
INDEX_W, 6, log2 of BTB entries (64 entries)
TAG_W, 10, tag width taken from PC bits above the index
CNT_INIT, 2'b10, counter value written on allocation (weakly taken)

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-low (rst == 0 resets on the rising edge of clk)
stall  input  6  pipeline stall vector; stall[0] == 1 freezes the fetch stage
flush  input  1  pipeline flush
query_ce  input  1  fetch enable; 0 means no valid fetch this cycle
query_pc  input  32  fetch PC being sent to the icache this cycle
pta  output  `SIZE_OF_PTA  prediction for the previous cycle's query_pc; `PTA_DIR` = predicted taken, `PTA_PADDR` = predicted target
upd_valid  input  1  EX reports a resolved branch/jump this cycle
upd_pc  input  32  PC of the resolved branch
upd_taken  input  1  actual direction (1 = taken)
upd_target  input  32  actual target address
hit_o  output  1  registered BTB tag hit for the current `pta` (performance counters)

Behaviour:
- Address split:
  - idx = pc[INDEX_W+1:2]
  - tag = pc[INDEX_W+TAG_W+1:INDEX_W+2]
- Storage per entry: valid (1), tag (TAG_W), target (32), cnt (2).
  - Only valid bits are reset.
  - tag/target/cnt are undefined until first allocated.
- Reset (rst == 0 at clk edge): all valid bits, pta, hit_o and the pending-update register go to 0.
- Lookup, 1-cycle latency:
  - At each clk edge, if stall[0] == 0 and flush == 0, register the result for query_pc:
    - hit = query_ce && valid[idx] && tag match
    - `pta` = {hit && cnt[1], hit ? target : 32'h0}
    - hit_o = hit
- Stall: if stall[0] == 1 (and flush == 0), pta and hit_o hold their values.
- Flush: flush == 1 clears pta and hit_o to 0 at the next edge, regardless of stall. The table is not cleared.
- query_ce == 0: result registers load 0, unless stalled.
- Update pipeline, two stages:
  - Stage U1: upd_* is captured into a pending register (p_valid, p_idx, p_tag, p_taken, p_target, p_hit, p_cnt).
    - p_hit and p_cnt are read from the table in the same cycle.
  - Stage U2: the table is written at the next edge. Updates are never dropped by stall or flush.
- U2 write rules:
  - Hit, taken: cnt = min(cnt+1, 3); target = p_target.
  - Hit, not taken: cnt = max(cnt-1, 0); target unchanged.
  - Miss, taken: allocate. valid = 1, tag = p_tag, target = p_target, cnt = CNT_INIT. Any existing entry at that index is overwritten.
  - Miss, not taken: no write.
- Read-during-write forwarding:
  - If a lookup or U1 read hits the same idx that U2 writes in the same cycle, it uses the values being written.
  - Back-to-back updates to the same branch therefore saturate correctly: two consecutive taken updates from cnt = 1 give 3.
- Simultaneous events:
  - Reset overrides everything.
  - Flush does not cancel U1/U2.
  - A lookup and an update in the same cycle are both serviced; there is one read port for fetch, one read for U1, and one write.
- No internal FSM beyond the pending-update valid bit. Throughput is one lookup plus one update per cycle.

Test Plan:
- Reset, then query_pc = 0xBFC00000 with query_ce = 1 for 3 cycles → pta = 0 and hit_o = 0 each cycle.
- upd_valid with pc = 0x80001000, taken = 1, target = 0x80002000 → after 2 cycles, query 0x80001000 → next-cycle pta dir = 1, paddr = 0x80002000, hit_o = 1.
- Same pc, then updates not-taken ×2 (cnt 2→1→0) → pta dir = 0, paddr = 0x80002000. Then one taken update → cnt = 1, dir still 0.
- Aliasing: allocate 0x80001000, then update taken for 0x80011000 (same idx, different tag) → query 0x80001000 gives hit_o = 0, pta = 0.
- Query the trained pc with stall[0] = 1 for 4 cycles → pta holds the prior value. Assert flush during the stall → pta = 0 on the next cycle.
- Update and lookup for the same idx in the U2 write cycle → lookup returns the newly written target/counter (forwarded). Assert rst = 0 mid-sequence → all subsequent lookups miss.
